// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with TX FIFO, status register and done interrupt
module uart_tx_periph #(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] BASE_PAGE    = 8'h03
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

    logic [1:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          ovf;
    logic          sel, push, clr, empty, full, busy, baud_last, pop, push_ok;
    logic          unused_bits;

    assign sel       = addr[15:8] == BASE_PAGE;
    assign push      = sel & we & (addr[7:0] == 8'h00);
    assign clr       = sel & we & (addr[7:0] == 8'h04) & wdata[3];
    assign empty     = count == '0;
    assign full      = count == (AW+1)'(FIFO_DEPTH);
    assign busy      = state != IDLE;
    assign irq       = empty & ~busy;
    assign baud_last = baud == BW'(CLKS_PER_BIT - 1);
    // Pops only happen at frame start, including the back-to-back start out of STOP
    assign pop       = ~empty & ((state == IDLE) | ((state == STOP) & baud_last));
    assign push_ok   = push & (~full | pop);
    assign unused_bits = ^{addr[31:16], wdata[31:8]};

    always_comb begin
        rdata = '0;
        if (sel && addr[7:0] == 8'h04) begin
            rdata[3:0]        = {ovf, busy, empty, full};
            rdata[4 +: AW+1]  = count;
        end
    end

    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= wdata[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
            if (push & full & ~pop) ovf <= 1'b1;
            else if (clr) ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            baud  <= '0;
            idx   <= '0;
            shift <= '0;
            tx    <= 1'b1;
        end else begin
            baud <= (state == IDLE || baud_last) ? '0 : baud + 1'b1;
            case (state)
                IDLE: if (pop) begin
                    shift <= mem[rd_ptr];
                    state <= START;
                    tx    <= 1'b0;
                end
                START: if (baud_last) begin
                    state <= DATA;
                    idx   <= '0;
                    tx    <= shift[0];
                end
                DATA: if (baud_last) begin
                    shift <= shift >> 1;
                    idx   <= idx + 1'b1;
                    state <= (idx == 3'd7) ? STOP : DATA;
                    tx    <= (idx == 3'd7) ? 1'b1 : shift[1];
                end
                default: if (baud_last) begin
                    state <= pop ? START : IDLE;
                    tx    <= ~pop;
                    if (pop) shift <= mem[rd_ptr];
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: checks the UART peripheral against a frame/queue-level reference model
module tb_uart_tx_periph;
    localparam int CPB = 4, DEPTH = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        tx;
        logic        irq;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        tx, irq;
    int          checks = 0, errors = 0;
    byte unsigned q[$];
    byte unsigned cur;
    bit          active, ovf;
    int          t;
    vec_t        vt[8];

    always #5 clk = ~clk;

    uart_tx_periph #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE_PAGE(8'h03)) dut (
        .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .tx(tx), .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {23'b0, 5'(q.size()), ovf, active, q.size() == 0, q.size() == DEPTH};
    endfunction

    // Frame = start(0), 8 data bits LSB first, stop(1); each bit lasts CPB cycles
    function automatic logic frame_bit(input byte unsigned b, input int k);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[k / CPB];
    endfunction

    function automatic logic m_tx();
        return active ? frame_bit(cur, t) : 1'b1;
    endfunction

    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic       sel;
        logic [7:0] off;
        bit         popped, full_pre;
        rst = r; we = w; addr = a; wdata = d;
        @(posedge clk);
        sel = a[15:8] == 8'h03;
        off = a[7:0];
        if (r) begin
            q.delete();
            active = 0; ovf = 0; t = 0;
        end else begin
            popped = 0;
            full_pre = q.size() == DEPTH;
            if (active && t < 10 * CPB - 1) t++;
            else if (q.size() > 0) begin
                cur = q.pop_front(); active = 1; t = 0; popped = 1;
            end else active = 0;
            if (sel && w && off == 8'h00) begin
                if (!full_pre || popped) q.push_back(d[7:0]);
                else ovf = 1;
            end
            if (sel && w && off == 8'h04 && d[3]) ovf = 0;
        end
        #1;
        chk("tx", tx, m_tx());
        chk("irq", irq, q.size() == 0 && !active);
        chk("rdata", rdata, (sel && off == 8'h04) ? m_status() : 32'h0);
    endtask

    initial begin
        vt[0] = '{1'b1, 32'h0000_0200, 32'h0000_00FF, 32'h0, 1'b1, 1'b1};
        vt[1] = '{1'b0, 32'h0000_0308, 32'h0,         32'h0, 1'b1, 1'b1};
        vt[2] = '{1'b0, 32'h0000_0304, 32'h0,         32'h2, 1'b1, 1'b1};
        vt[3] = '{1'b1, 32'h0000_0304, 32'h0000_0008, 32'h2, 1'b1, 1'b1};
        vt[4] = '{1'b1, 32'h0000_030C, 32'h0000_00AB, 32'h0, 1'b1, 1'b1};
        vt[5] = '{1'b0, 32'h0000_0300, 32'h0,         32'h0, 1'b1, 1'b1};
        vt[6] = '{1'b0, 32'h0001_0304, 32'h0,         32'h2, 1'b1, 1'b1};
        vt[7] = '{1'b1, 32'h0000_0204, 32'h0000_0008, 32'h0, 1'b1, 1'b1};

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 32'h304, 0);
        chk("reset_tx", tx, 1);
        chk("reset_status", rdata, 32'h2);
        chk("reset_irq", irq, 1);

        foreach (vt[i]) begin
            step(0, vt[i].we, vt[i].addr, vt[i].wdata);
            chk("vec_rdata", rdata, vt[i].rdata);
            chk("vec_tx", tx, vt[i].tx);
            chk("vec_irq", irq, vt[i].irq);
        end
        step(0, 0, 32'h304, 0);
        chk("vec_no_push", rdata, 32'h2);

        step(0, 1, 32'h300, 32'hFFFF_FFA5);
        chk("a5_latency_tx", tx, 1);
        for (int k = 0; k < 10 * CPB; k++) begin
            step(0, 0, 32'h304, 0);
            chk("a5_tx", tx, frame_bit(8'hA5, k));
            chk("a5_busy", rdata[2], 1);
        end
        step(0, 0, 32'h304, 0);
        chk("a5_done_status", rdata, 32'h2);
        chk("a5_done_irq", irq, 1);

        step(0, 1, 32'h300, 32'h55);
        step(0, 1, 32'h300, 32'h0F);
        for (int i = 0; i < 20 * CPB; i++) begin
            if (i > 0) step(0, 0, 32'h304, 0);
            chk("b2b_tx", tx, frame_bit(i < 10 * CPB ? 8'h55 : 8'h0F, i % (10 * CPB)));
            if (i == 1) chk("b2b_count", rdata[8:4], 1);
        end
        step(0, 0, 32'h304, 0);
        chk("b2b_irq", irq, 1);

        step(0, 1, 32'h300, 32'h11);
        step(0, 1, 32'h300, 32'h22);
        step(0, 1, 32'h300, 32'h33);
        step(0, 1, 32'h300, 32'h44);
        step(0, 1, 32'h300, 32'h5A);
        step(0, 1, 32'h300, 32'h66);
        step(0, 0, 32'h304, 0);
        chk("ovf_status", rdata, 32'h4D);
        step(0, 1, 32'h304, 32'h8);
        chk("ovf_clear", rdata, 32'h45);
        for (int i = 0; i < 55 * CPB; i++) step(0, 0, 32'h304, 0);
        chk("ovf_drained_irq", irq, 1);

        step(0, 1, 32'h300, 32'hC3);
        step(0, 1, 32'h300, 32'h3C);
        step(0, 1, 32'h300, 32'h99);
        for (int i = 0; i < 2 * CPB; i++) step(0, 0, 32'h304, 0);
        step(1, 0, 32'h304, 0);
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_status", rdata, 32'h2);
        for (int i = 0; i < 15 * CPB; i++) begin
            step(0, 0, 32'h304, 0);
            chk("rst_quiet_tx", tx, 1);
        end

        for (int i = 0; i < 1500; i++) begin
            int          r;
            logic [7:0]  page, off;
            r    = $urandom_range(0, 199);
            page = ($urandom_range(0, 3) == 0) ? 8'h02 : 8'h03;
            case ($urandom_range(0, 3))
                0, 1:    off = 8'h00;
                2:       off = 8'h04;
                default: off = 8'h08;
            endcase
            step(r == 0, r < 14, {16'($urandom), page, off}, $urandom);
        end
        for (int i = 0; i < 60 * CPB; i++) step(0, 0, 32'h304, 0);
        chk("final_irq", irq, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
